// File: rtl/equal.sv
// Race-logic temporal EQUAL gate.
// Each input carries one value per gamma cycle as the arrival time of its
// leading edge. y reproduces that arrival time (as a PULSE_WIDTH-cycle pulse)
// only when a and b arrive in the same clock sample; otherwise y stays idle
// for the whole gamma cycle, which encodes "infinity".
// Optional build macro EQUAL_FALLING_EDGE_EN switches to falling-edge coding:
// idle level 1, events are 1->0 transitions, the output pulse is driven low.
// The first sample after any reset only captures the input level, so an
// input that is already at its active level when reset releases never counts
// as an arrival.
`default_nettype none

module equal #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y
);

  localparam int GCNT_W = $clog2(GAMMA_CYCLE_WIDTH + 1);
  localparam int PCNT_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [GCNT_W-1:0] GAMMA_END  = GCNT_W'(GAMMA_CYCLE_WIDTH);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_WIDTH - 1);

`ifdef EQUAL_FALLING_EDGE_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif

  logic              a_q;
  logic              b_q;
  logic              done;
  logic              primed;
  logic              y_r;
  logic [PCNT_W-1:0] pcnt;
  logic [GCNT_W-1:0] gcnt;

  logic ea;
  logic eb;
  logic win;
  logic pulsing;

  // Arrival detection: a transition away from the idle level, ignored on the
  // first sample after reset since there is no real previous sample yet.
  always_comb begin
    ea      = primed & (a_q == IDLE) & (a != IDLE);
    eb      = primed & (b_q == IDLE) & (b != IDLE);
    win     = (gcnt < GAMMA_END);
    pulsing = (y_r != IDLE);
  end

  // Gamma-cycle state: position counter, one-shot resolve, and output pulse.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      a_q    <= IDLE;
      b_q    <= IDLE;
      done   <= 1'b0;
      primed <= 1'b0;
      y_r    <= IDLE;
      pcnt   <= '0;
      gcnt   <= '0;
    end else if (rst) begin
      a_q    <= IDLE;
      b_q    <= IDLE;
      done   <= 1'b0;
      primed <= 1'b0;
      y_r    <= IDLE;
      pcnt   <= '0;
      gcnt   <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      primed <= 1'b1;
      if (win) begin
        gcnt <= gcnt + GCNT_W'(1);
      end
      if (!win) begin
        y_r  <= IDLE;
        pcnt <= '0;
      end else if (pulsing) begin
        if (pcnt != '0) begin
          pcnt <= pcnt - PCNT_W'(1);
        end else begin
          y_r <= IDLE;
        end
      end else if (!done && ea && eb) begin
        y_r  <= ~IDLE;
        pcnt <= PULSE_LOAD;
        done <= 1'b1;
      end else if (!done && (ea ^ eb)) begin
        done <= 1'b1;
      end
    end
  end

  assign y = y_r;

endmodule

`default_nettype wire

// File: tb/tb_equal.sv
// Testbench for the race-logic EQUAL gate: directed scenarios followed by
// randomized gamma cycles, all checked against a reference model that works
// from first-arrival times rather than from edge-detector state.
`timescale 1ns/1ps

module tb_equal;

  localparam int GAMMA = 16;
  localparam int PULSE = 8;

`ifdef EQUAL_FALLING_EDGE_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif

  logic aclk;
  logic grst;
  logic rst;
  logic a;
  logic b;
  logic y;

  int checks   = 0;
  int failures = 0;

  // Reference model state: sample index within the gamma cycle, previous
  // input levels and the first arrival time of each input (-1 = none yet).
  int   idx;
  logic prevA;
  logic prevB;
  int   aRise;
  int   bRise;
  logic expY;

  equal #(
    .GAMMA_CYCLE_WIDTH(GAMMA),
    .PULSE_WIDTH(PULSE)
  ) dut (
    .aclk(aclk),
    .grst(grst),
    .rst(rst),
    .a(a),
    .b(b),
    .y(y)
  );

  // Free-running clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic logic lvl(input bit on);
    return on ? ~IDLE : IDLE;
  endfunction

  task automatic modelReset();
    idx   = 0;
    prevA = IDLE;
    prevB = IDLE;
    aRise = -1;
    bRise = -1;
    expY  = IDLE;
  endtask

  // Arrival = first move away from idle inside the window (sample 0 after a
  // reset only establishes the level). y is active for PULSE samples from a
  // shared arrival, truncated at the end of the window.
  task automatic modelStep(input logic na, input logic nb);
    if (idx > 0 && idx < GAMMA) begin
      if (aRise < 0 && prevA == IDLE && na != IDLE) aRise = idx;
      if (bRise < 0 && prevB == IDLE && nb != IDLE) bRise = idx;
    end
    prevA = na;
    prevB = nb;
    if (aRise >= 0 && aRise == bRise && idx >= aRise &&
        idx < aRise + PULSE && idx < GAMMA)
      expY = ~IDLE;
    else
      expY = IDLE;
    idx++;
  endtask

  task automatic checkOutput(input string tag, input logic want);
    checks++;
    assert (y === want) else begin
      failures++;
      $error("[TB] FAIL %s: y=%b expected=%b", tag, y, want);
    end
  endtask

  task automatic applyStimulus(input logic na, input logic nb, input string tag);
    @(negedge aclk);
    a = na;
    b = nb;
    modelStep(na, nb);
    @(posedge aclk);
    #1;
    checkOutput(tag, expY);
  endtask

  task automatic doRst(input logic na, input logic nb);
    @(negedge aclk);
    rst = 1'b1;
    a   = na;
    b   = nb;
    @(posedge aclk);
    #1;
    checkOutput("rst", IDLE);
    rst = 1'b0;
    modelReset();
  endtask

  // Called right after a checked posedge: pulse grst low well before the
  // next negedge and confirm y drops without waiting for a clock.
  task automatic doGrst();
    #1 grst = 1'b0;
    #1 checkOutput("grst_async", IDLE);
    #1 grst = 1'b1;
    modelReset();
  endtask

  task automatic runWave(input int ta, input int wa, input int tb, input int wb,
                         input int len, input string tag);
    for (int j = 0; j < len; j++)
      applyStimulus(lvl(j >= ta && j < ta + wa), lvl(j >= tb && j < tb + wb), tag);
  endtask

  initial begin
    grst = 1'b0;
    rst  = 1'b0;
    a    = IDLE;
    b    = IDLE;
    modelReset();

    @(posedge aclk);
    #1 checkOutput("reset_state", IDLE);
    #2 grst = 1'b1;

    $display("[TB] idle gamma cycle");
    runWave(0, 0, 0, 0, GAMMA + 2, "no_edges");

    $display("[TB] a before b");
    doRst(IDLE, IDLE);
    runWave(2, 8, 4, 8, GAMMA + 2, "a_first");

    $display("[TB] b before a");
    doRst(IDLE, IDLE);
    runWave(4, 8, 2, 8, GAMMA + 2, "b_first");

    $display("[TB] simultaneous arrival");
    doRst(IDLE, IDLE);
    runWave(2, 8, 2, 8, GAMMA + 2, "together");

    $display("[TB] short inputs, long pulse, second arrival ignored");
    doRst(IDLE, IDLE);
    runWave(3, 1, 3, 2, 6, "short_in");
    runWave(0, 3, 0, 3, GAMMA, "second_edge");

    $display("[TB] rst mid-pulse then fresh arrival");
    doRst(IDLE, IDLE);
    runWave(2, 8, 2, 8, 5, "pre_rst");
    doRst(~IDLE, ~IDLE);
    applyStimulus(~IDLE, ~IDLE, "held_through_rst");
    applyStimulus(IDLE, IDLE, "post_rst_idle");
    runWave(0, 10, 0, 10, GAMMA, "refire");

    $display("[TB] grst mid-pulse, inputs held active");
    doRst(IDLE, IDLE);
    runWave(1, 20, 1, 20, 4, "pre_grst");
    doGrst();
    runWave(0, 6, 0, 6, 6, "post_grst_held");

    $display("[TB] arrivals at the window boundary");
    doRst(IDLE, IDLE);
    runWave(GAMMA - 1, 4, GAMMA - 1, 4, GAMMA + 3, "last_slot");
    doRst(IDLE, IDLE);
    runWave(GAMMA, 4, GAMMA, 4, GAMMA + 4, "closed_slot");

    $display("[TB] randomized gamma cycles");
    for (int g = 0; g < 40; g++) begin
      int  ta, tb, wa, wb;
      bit  noise;
      ta    = $urandom_range(0, GAMMA + 1);
      tb    = ($urandom % 2 == 0) ? ta : $urandom_range(0, GAMMA + 1);
      wa    = $urandom_range(1, 10);
      wb    = $urandom_range(1, 10);
      noise = ($urandom % 4 == 0);
      doRst(lvl($urandom % 2 == 1), lvl($urandom % 2 == 1));
      for (int j = 0; j < GAMMA + 3; j++) begin
        if (noise)
          applyStimulus(lvl($urandom % 2 == 1), lvl($urandom % 2 == 1), "rand_noise");
        else
          applyStimulus(lvl(j >= ta && j < ta + wa), lvl(j >= tb && j < tb + wb), "rand_wave");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
